pa_clic_kid_cfg: RTL and testbench

PA_CLIC_KID_CFG -- requirements
Module: pa_clic_kid_cfg

---
 rtl/pa_clic_kid_cfg.sv | 109 ++++++++++
 tb/tb_pa_clic_kid_cfg.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pa_clic_kid_cfg.sv
// One CLIC interrupt source: input synchroniser, trigger handling, and its
// ip/ie/attr/ctl register word.
module pa_clic_kid_cfg #(
  parameter int CLICINTCTLBITS = 3,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      forever_cpuclk,
  input  logic                      cpurst,
  input  logic                      pad_clic_int_vld,
  input  logic                      busif_kid_sel,
  input  logic [3:0]                busif_kid_we,
  input  logic [31:0]               busif_kid_wdata,
  input  logic                      arb_kid_ack,
  output logic [CLICINTCTLBITS:0]   kid_arb_int_all,
  output logic                      kid_arb_int_hv,
  output logic                      kid_arb_int_req,
  output logic [31:0]               kid_busif_rdata
);

  localparam int N = CLICINTCTLBITS;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   int_sync, int_prev_q;
  logic                   edge_q, edge_d;
  logic                   ip_edge_q, ip_edge_d;
  logic                   ie_q, shv_q;
  logic [1:0]             trig_q;
  logic [N-1:0]           ctl_q;
  logic                   wr_ip, wr_ie, wr_attr, wr_ctl;
  logic                   edge_mode, edge_det, trig_change, ip, req;
  logic [7:0]             ctl_byte;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_d[gi] = pad_clic_int_vld;
      end else begin : g_next
        assign sync_d[gi] = sync_q[gi-1];
      end
    end
  endgenerate

  assign int_sync = sync_q[SYNC_STAGES-1];

  assign wr_ip   = busif_kid_sel & busif_kid_we[0];
  assign wr_ie   = busif_kid_sel & busif_kid_we[1];
  assign wr_attr = busif_kid_sel & busif_kid_we[2];
  assign wr_ctl  = busif_kid_sel & busif_kid_we[3];

  // trig[0] selects edge sensitivity, trig[1] selects the active-low polarity.
  assign edge_mode   = trig_q[0];
  assign edge_det    = trig_q[1] ? (~int_sync & int_prev_q) : (int_sync & ~int_prev_q);
  assign trig_change = wr_attr & (busif_kid_wdata[18:17] != trig_q);

  // The detected edge is registered once before it reaches ip; a trigger
  // change kills both the pending ip and any edge in flight.
  assign edge_d = edge_mode & edge_det & ~trig_change;

  always_comb begin
    ip_edge_d = ip_edge_q;
    if (!edge_mode || trig_change) ip_edge_d = 1'b0;
    else if (edge_q)               ip_edge_d = 1'b1;
    else if (wr_ip)                ip_edge_d = busif_kid_wdata[0];
    else if (arb_kid_ack)          ip_edge_d = 1'b0;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      sync_q     <= '0;
      int_prev_q <= 1'b0;
      edge_q     <= 1'b0;
      ip_edge_q  <= 1'b0;
      ie_q       <= 1'b0;
      shv_q      <= 1'b0;
      trig_q     <= 2'b00;
      ctl_q      <= '0;
    end else begin
      sync_q     <= sync_d;
      int_prev_q <= int_sync;
      edge_q     <= edge_d;
      ip_edge_q  <= ip_edge_d;
      if (wr_ie) ie_q <= busif_kid_wdata[8];
      if (wr_attr) begin
        shv_q  <= busif_kid_wdata[16];
        trig_q <= busif_kid_wdata[18:17];
      end
      if (wr_ctl) ctl_q <= busif_kid_wdata[31 -: N];
    end
  end

  assign ip  = edge_mode ? ip_edge_q : (int_sync ^ trig_q[1]);
  assign req = ip & ie_q;

  assign kid_arb_int_req = req;
  assign kid_arb_int_hv  = shv_q;
  assign kid_arb_int_all = req ? {1'b1, ctl_q} : '0;

  // Unimplemented low priority bits read back as 1.
  always_comb begin
    ctl_byte          = 8'hFF;
    ctl_byte[7 -: N]  = ctl_q;
  end

  assign kid_busif_rdata = busif_kid_sel
                         ? {ctl_byte, 2'b11, 3'b000, trig_q, shv_q, 7'b0, ie_q, 7'b0, ip}
                         : 32'h0;

endmodule

// File: tb/tb_pa_clic_kid_cfg.sv
// Directed bench for pa_clic_kid_cfg (CLICINTCTLBITS=3, SYNC_STAGES=2).
module tb_pa_clic_kid_cfg;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst;
  logic        pad_clic_int_vld;
  logic        busif_kid_sel;
  logic [3:0]  busif_kid_we;
  logic [31:0] busif_kid_wdata;
  logic        arb_kid_ack;
  logic [3:0]  kid_arb_int_all;
  logic        kid_arb_int_hv;
  logic        kid_arb_int_req;
  logic [31:0] kid_busif_rdata;

  int cmp_cnt = 0;
  int err_cnt = 0;

  pa_clic_kid_cfg #(.CLICINTCTLBITS(3), .SYNC_STAGES(2)) dut (
    .forever_cpuclk  (forever_cpuclk),
    .cpurst          (cpurst),
    .pad_clic_int_vld(pad_clic_int_vld),
    .busif_kid_sel   (busif_kid_sel),
    .busif_kid_we    (busif_kid_we),
    .busif_kid_wdata (busif_kid_wdata),
    .arb_kid_ack     (arb_kid_ack),
    .kid_arb_int_all (kid_arb_int_all),
    .kid_arb_int_hv  (kid_arb_int_hv),
    .kid_arb_int_req (kid_arb_int_req),
    .kid_busif_rdata (kid_busif_rdata)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  task automatic tick(input int n);
    repeat (n) @(posedge forever_cpuclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wr(input logic [3:0] we, input logic [31:0] data);
    busif_kid_sel   = 1'b1;
    busif_kid_we    = we;
    busif_kid_wdata = data;
    tick(1);
    busif_kid_we    = 4'h0;
    busif_kid_wdata = 32'h0;
    #1;
  endtask

  initial begin
    cpurst = 1'b1; pad_clic_int_vld = 1'b0; busif_kid_sel = 1'b0;
    busif_kid_we = 4'h0; busif_kid_wdata = 32'h0; arb_kid_ack = 1'b0;
    tick(3);
    cpurst = 1'b0; busif_kid_sel = 1'b1; #1;
    chk("rst_rdata", kid_busif_rdata, 32'h1FC0_0000);
    chk("rst_req",   32'(kid_arb_int_req), 32'h0);
    chk("rst_all",   32'(kid_arb_int_all), 32'h0);
    chk("rst_hv",    32'(kid_arb_int_hv),  32'h0);

    // ctl=101, rising, shv, ie in one multi-byte write
    wr(4'b1110, 32'hA003_0100);
    chk("cfg_rdata", kid_busif_rdata, 32'hBFC3_0100);
    chk("cfg_hv",    32'(kid_arb_int_hv), 32'h1);
    pad_clic_int_vld = 1'b1; tick(1); pad_clic_int_vld = 1'b0;
    tick(2);
    chk("rise_lat3",  32'(kid_arb_int_req), 32'h0);
    tick(1);
    chk("rise_lat4",  32'(kid_arb_int_req), 32'h1);
    chk("rise_all",   32'(kid_arb_int_all), 32'hD);
    chk("rise_rdata", kid_busif_rdata, 32'hBFC3_0101);
    arb_kid_ack = 1'b1; tick(1); arb_kid_ack = 1'b0;
    chk("ack_clr",    32'(kid_arb_int_req), 32'h0);

    // level-high
    wr(4'b0100, 32'h0000_0000);
    chk("lvl_hv",    32'(kid_arb_int_hv),  32'h0);
    chk("lvl_rdata", kid_busif_rdata, 32'hBFC0_0100);
    pad_clic_int_vld = 1'b1; tick(1);
    chk("lvl_lat1",  32'(kid_arb_int_req), 32'h0);
    tick(1);
    chk("lvl_lat2",  32'(kid_arb_int_req), 32'h1);
    wr(4'b0001, 32'h0000_0000);
    chk("lvl_swip",  kid_busif_rdata, 32'hBFC0_0101);
    pad_clic_int_vld = 1'b0; tick(1);
    chk("lvl_fall1", 32'(kid_arb_int_req), 32'h1);
    tick(1);
    chk("lvl_fall2", 32'(kid_arb_int_req), 32'h0);

    // level-low
    wr(4'b0100, 32'h0004_0000);
    chk("low_idle",  32'(kid_arb_int_req), 32'h1);
    pad_clic_int_vld = 1'b1; tick(2);
    chk("low_high",  32'(kid_arb_int_req), 32'h0);
    pad_clic_int_vld = 1'b0; tick(2);
    chk("low_back",  32'(kid_arb_int_req), 32'h1);

    // rising: edge, ip write 0 and ack in the same cycle
    wr(4'b0100, 32'h0002_0000);
    chk("edge_clr",  32'(kid_arb_int_req), 32'h0);
    pad_clic_int_vld = 1'b1; tick(3);
    chk("prio_pre",  32'(kid_arb_int_req), 32'h0);
    busif_kid_we = 4'b0001; busif_kid_wdata = 32'h0; arb_kid_ack = 1'b1;
    tick(1);
    busif_kid_we = 4'h0; arb_kid_ack = 1'b0; #1;
    chk("prio_edge", 32'(kid_arb_int_req), 32'h1);

    // trig change to falling clears ip; later falling edge sets it
    wr(4'b0100, 32'h0006_0000);
    chk("trig_clr",  32'(kid_arb_int_req), 32'h0);
    pad_clic_int_vld = 1'b0; tick(3);
    chk("fall_lat3", 32'(kid_arb_int_req), 32'h0);
    tick(1);
    chk("fall_lat4", 32'(kid_arb_int_req), 32'h1);

    // unselected write is ignored
    busif_kid_sel = 1'b0; busif_kid_we = 4'hF; busif_kid_wdata = 32'h0; #1;
    chk("nosel_rd",  kid_busif_rdata, 32'h0);
    tick(1);
    busif_kid_we = 4'h0; busif_kid_sel = 1'b1; #1;
    chk("nosel_req", 32'(kid_arb_int_req), 32'h1);
    chk("nosel_all", 32'(kid_arb_int_all), 32'hD);
    chk("nosel_reg", kid_busif_rdata, 32'hBFC6_0101);

    // software ip load in edge mode
    wr(4'b0001, 32'h0000_0000);
    chk("sw_ip0",    32'(kid_arb_int_req), 32'h0);
    wr(4'b0001, 32'h0000_0001);
    chk("sw_ip1",    32'(kid_arb_int_req), 32'h1);

    // reset while pending, source high across release
    cpurst = 1'b1; pad_clic_int_vld = 1'b1; tick(2);
    chk("rst2_req",   32'(kid_arb_int_req), 32'h0);
    chk("rst2_all",   32'(kid_arb_int_all), 32'h0);
    chk("rst2_rdata", kid_busif_rdata, 32'h1FC0_0000);
    cpurst = 1'b0;
    wr(4'b0110, 32'h0002_0100);
    tick(2);
    chk("rel_lat3",  32'(kid_arb_int_req), 32'h0);
    tick(1);
    chk("rel_lat4",  32'(kid_arb_int_req), 32'h1);
    chk("rel_rdata", kid_busif_rdata, 32'h1FC2_0101);
    arb_kid_ack = 1'b1; tick(1); arb_kid_ack = 1'b0;
    tick(5);
    chk("rel_once",  32'(kid_arb_int_req), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
